// File: rtl/log_ram_mc.sv
// Multi-channel logging RAM: captures N_CH sample streams under a start/stop FSM
// (one-shot or circular) and reads back any channel oldest-first with 1-cycle latency.
//
// state   | meaning
// IDLE    | after reset, nothing captured yet
// CAPTURE | writing samples on i_valid, readout blocked
// DONE    | contents frozen, readout allowed
module log_ram_mc #(
  parameter int NB_DATA = 16,
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 10,
  parameter int NB_SEL  = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [N_CH*NB_DATA-1:0] i_data,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic                    i_mode,
  input  logic                    i_rd_en,
  input  logic [NB_SEL-1:0]       i_rd_ch,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic [NB_DATA-1:0]      o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_busy,
  output logic                    o_full,
  output logic [ADDR_W:0]         o_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [NB_SEL:0] CH_LIM    = (NB_SEL+1)'(N_CH);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                busy_q, busy_d;
  logic [NB_DATA-1:0]  rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_en;
  logic [ADDR_W-1:0]   rd_phys;
  logic                rd_ok;
  logic [NB_DATA-1:0]  rd_word;

  logic [NB_DATA-1:0]  ram_q [N_CH][DEPTH];

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d  = CAPTURE;
          mode_d   = i_mode;
          wr_ptr_d = '0;
          count_d  = '0;
          full_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (i_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != DEPTH_CNT) count_d = count_q + 1'b1;
          if (count_d == DEPTH_CNT) full_d = 1'b1;
          // One-shot stops on the write that fills the buffer
          if (!mode_q && count_d == DEPTH_CNT) state_d = DONE;
        end
        if (i_stop) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CAPTURE);
  end

  // Once wrapped, the write pointer marks the oldest sample
  always_comb begin
    rd_phys = (full_q ? wr_ptr_q : '0) + i_rd_addr;
    rd_ok   = i_rd_en && (state_q != CAPTURE) &&
              ({1'b0, i_rd_ch} < CH_LIM) && ({1'b0, i_rd_addr} < count_q);
    rd_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_rd_ch == NB_SEL'(k)) rd_word = ram_q[k][rd_phys];
    end
    rd_data_d  = rd_ok ? rd_word : rd_data_q;
    rd_valid_d = rd_ok;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      for (int k = 0; k < N_CH; k++) ram_q[k][wr_ptr_q] <= i_data[k*NB_DATA +: NB_DATA];
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = busy_q;
  assign o_full     = full_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_log_ram_mc.sv
// Directed bench for log_ram_mc (DEPTH=8, 2 channels): read expectations go through
// a scoreboard queue and are checked one cycle after each request.
module tb_log_ram_mc;
  localparam int NB_DATA = 16;
  localparam int N_CH    = 2;
  localparam int ADDR_W  = 3;
  localparam int NB_SEL  = 1;

  logic                    i_clock = 1'b0;
  logic                    i_reset = 1'b0;
  logic                    i_valid = 1'b0;
  logic [N_CH*NB_DATA-1:0] i_data  = '0;
  logic                    i_start = 1'b0;
  logic                    i_stop  = 1'b0;
  logic                    i_mode  = 1'b0;
  logic                    i_rd_en = 1'b0;
  logic [NB_SEL-1:0]       i_rd_ch = '0;
  logic [ADDR_W-1:0]       i_rd_addr = '0;
  logic [NB_DATA-1:0]      o_rd_data;
  logic                    o_rd_valid;
  logic                    o_busy;
  logic                    o_full;
  logic [ADDR_W:0]         o_count;

  log_ram_mc #(.NB_DATA(NB_DATA), .N_CH(N_CH), .ADDR_W(ADDR_W), .NB_SEL(NB_SEL)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode), .i_rd_en(i_rd_en),
    .i_rd_ch(i_rd_ch), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_full(o_full), .o_count(o_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        v;
    logic [15:0] d;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] last_d = '0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic pulse_start(input logic mode);
    i_start = 1'b1;
    i_mode  = mode;
    tick();
    i_start = 1'b0;
  endtask

  task automatic sample(input int n, input logic stop);
    i_valid = 1'b1;
    i_stop  = stop;
    i_data  = {16'(16'h100 + n), 16'(n)};
    tick();
    i_valid = 1'b0;
    i_stop  = 1'b0;
  endtask

  // One read request per call; result is compared on the following edge
  task automatic rd(input string tag, input logic en, input logic [NB_SEL-1:0] ch,
                    input logic [ADDR_W-1:0] addr, input logic ev, input logic [15:0] ed);
    exp_t e;
    exp_t got_e;
    i_rd_en   = en;
    i_rd_ch   = ch;
    i_rd_addr = addr;
    e.v = ev;
    e.d = ev ? ed : last_d;
    last_d = e.d;
    sb_q.push_back(e);
    tick();
    i_rd_en = 1'b0;
    got_e = sb_q.pop_front();
    check({tag, "_valid"}, 32'(o_rd_valid), 32'(got_e.v));
    check({tag, "_data"}, 32'(o_rd_data), 32'(got_e.d));
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_full", 32'(o_full), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_rd_valid", 32'(o_rd_valid), 0);
    check("rst_rd_data", 32'(o_rd_data), 0);
    i_reset = 1'b1;
    tick();

    // Stop in IDLE is ignored
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("idle_stop_busy", 32'(o_busy), 0);

    // Reset mid-capture aborts asynchronously
    pulse_start(1'b0);
    for (int n = 0; n < 3; n++) sample(n, 1'b0);
    check("mid_count", 32'(o_count), 3);
    check("mid_busy", 32'(o_busy), 1);
    #2 i_reset = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy), 0);
    check("arst_count", 32'(o_count), 0);
    check("arst_full", 32'(o_full), 0);
    #2 i_reset = 1'b1;
    tick();
    check("arst_idle", 32'(o_busy), 0);

    // One-shot fill
    pulse_start(1'b0);
    check("os_busy", 32'(o_busy), 1);
    for (int n = 0; n < 8; n++) sample(n, 1'b0);
    check("os_full", 32'(o_full), 1);
    check("os_done", 32'(o_busy), 0);
    check("os_count", 32'(o_count), 8);
    sample(8, 1'b0);
    sample(9, 1'b0);
    check("os_count_after", 32'(o_count), 8);
    for (int a = 0; a < 8; a++) rd("os_ch1", 1'b1, 1'b1, 3'(a), 1'b1, 16'(16'h100 + a));
    rd("os_ch0_a0", 1'b1, 1'b0, 3'd0, 1'b1, 16'd0);
    rd("os_ch0_a1", 1'b1, 1'b0, 3'd1, 1'b1, 16'd1);
    rd("rd_en_low", 1'b0, 1'b0, 3'd2, 1'b0, 16'd0);

    // Restart from DONE clears o_full on the start edge; circular wrap
    pulse_start(1'b1);
    check("rs_full", 32'(o_full), 0);
    check("rs_count", 32'(o_count), 0);
    check("rs_busy", 32'(o_busy), 1);
    for (int n = 0; n < 4; n++) sample(n, 1'b0);
    pulse_start(1'b0);
    check("cap_start_ignored", 32'(o_count), 4);
    for (int n = 4; n < 13; n++) sample(n, 1'b0);
    check("circ_full", 32'(o_full), 1);
    check("circ_count", 32'(o_count), 8);
    check("circ_busy", 32'(o_busy), 1);
    rd("rd_in_capture", 1'b1, 1'b0, 3'd0, 1'b0, 16'd0);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("circ_stop", 32'(o_busy), 0);
    check("circ_full_held", 32'(o_full), 1);
    for (int a = 0; a < 8; a++) rd("circ_ch0", 1'b1, 1'b0, 3'(a), 1'b1, 16'(5 + a));

    // Stop coincident with valid, then invalid / partial reads
    pulse_start(1'b1);
    for (int n = 0; n < 3; n++) sample(n, 1'b0);
    check("co_busy_before", 32'(o_busy), 1);
    sample(3, 1'b1);
    check("co_count", 32'(o_count), 4);
    check("co_busy", 32'(o_busy), 0);
    check("co_full", 32'(o_full), 0);
    rd("co_ch0_a3", 1'b1, 1'b0, 3'd3, 1'b1, 16'd3);
    rd("co_addr5", 1'b1, 1'b0, 3'd5, 1'b0, 16'd0);
    rd("co_addr4", 1'b1, 1'b1, 3'd4, 1'b0, 16'd0);
    rd("co_ch1_a2", 1'b1, 1'b1, 3'd2, 1'b1, 16'h102);

    // One-shot stopped early keeps the partial count
    pulse_start(1'b0);
    for (int n = 20; n < 22; n++) sample(n, 1'b0);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("os_early_count", 32'(o_count), 2);
    check("os_early_busy", 32'(o_busy), 0);
    rd("os_early_a1", 1'b1, 1'b0, 3'd1, 1'b1, 16'd21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
